tile_write_ctrl: RTL and testbench
==================================

Name: tile_write_ctrl

Overview:
- Sole owner of the display tile BRAM write port (port A); also owns the text cursor.
- Shares the port between three requesters: a full-screen clear engine, a terminal-style character stream (valid/ready), and cursor move pulses from the button edge detectors.
- Generates registered, one-cycle write strobes with tile address {row, col}. This is the same packing the pixel path uses on port B.
- Exports the cursor position for the cursor overlay.

Parameters:
COLS, 160, text columns (1280/8)
ROWS, 45, text rows (720/16)
COL_W, 8, column field width in address
ROW_W, 6, row field width in address
ADDR_W, 14, tile BRAM address width (ROW_W+COL_W)

Ports:
clk_75mhz  in  1  pixel/system clock
rst_sync  in  1  asynchronous, active-high reset
clear_req  in  1  single-cycle pulse: fill screen with fill_char
fill_char  in  8  ASCII code written by clear; sampled when clear starts
key_valid  in  1  character stream valid
key_char  in  8  character stream data
key_ready  out  1  character accepted when key_valid && key_ready
up_pulse, down_pulse, left_pulse, right_pulse  in  1 each  cursor move pulses
bram_we  out  1  port A write enable
bram_addr  out  ADDR_W  port A address {row, col}
bram_din  out  8  port A write data
cur_col  out  COL_W  cursor column
cur_row  out  ROW_W  cursor row
busy  out  1  high while clear in progress or pending

Behaviour:
- Reset: state IDLE; all outputs 0; clear_pending=0. key_ready=0 while rst_sync is high. Reset mid-clear aborts the clear; nothing resumes.
- States: IDLE, WRITE, CLEAR. All outputs are registered except key_ready and busy.
- key_ready = (state==IDLE) && !clear_pending && !clear_req.
- busy = (state==CLEAR) || clear_pending.
- clear_req handling:
  - Sets clear_pending. The pulse is recorded in any state except CLEAR.
  - In CLEAR, further clear_req is ignored.
- IDLE priority, highest first: clear_pending > key accept > cursor move.
- Clear start (IDLE with clear_pending):
  - Latch fill_char; clear clear_pending; ccol=0, crow=0; go to CLEAR.
- CLEAR:
  - One write per cycle: bram_we=1, addr={crow,ccol}, din=latched fill.
  - ccol counts 0..COLS-1, then wraps to 0 and increments crow; covers crow 0..ROWS-1.
  - Exactly COLS*ROWS = 7200 writes. Address column values 160..255 are never written.
  - After the last write (44,159): cursor set to (0,0), bram_we=0 next cycle, state IDLE.
  - Moves and keys are ignored during CLEAR.
- Key accept at edge ending cycle N:
  - Cycle N+1: bram_we/addr/din reflect the write, cursor outputs show the new position, state WRITE.
  - In WRITE: key_ready=0; next edge returns to IDLE. Max throughput is one character per 2 cycles.
  - bram_we is high for exactly one cycle per write.
- Character rules, where (c,r) is the cursor at accept:
  - Printable (0x20..0x7E) and any other code not listed below: write at (c,r), then advance.
    - Advance: c+1. At c=COLS-1, c=0 and r+1. At r=ROWS-1 and c=COLS-1, wrap to (0,0).
  - 0x0D (CR): c=0; no write (bram_we stays 0).
  - 0x0A (LF): c=0; r+1, wrapping ROWS-1 -> 0; no write.
  - 0x08 (BS): if c>0, c=c-1 and write 0x20 at the new (c-1,r). If c=0, no move and no write.
  - In all cases the state still passes through WRITE.
- Cursor moves (IDLE only, no key accept that cycle):
  - Honoured only if exactly one pulse is high; multiple simultaneous pulses are ignored.
  - up: r-1 if r>0. down: r+1 if r<ROWS-1. left: c-1 if c>0. right: c+1 if c<COLS-1.
  - Moves saturate and never wrap. No BRAM write.
  - Moves take effect on the next edge.
  - A move coinciding with a key accept is dropped. Moves in WRITE/CLEAR are dropped.
- Width rules:
  - bram_addr = {cur_row, cur_col} zero-extended to ADDR_W.
  - Counters never exceed COLS-1/ROWS-1.

Test Plan:
1. Reset then release, with key_valid=0 -> all outputs 0, key_ready=1 on the first cycle after release, cursor (0,0).
2. Key 0x43 accepted at (0,0) -> next cycle: we=1, addr=0x0000, din=0x43, cursor (1,0); key_ready=0 for one cycle; we low after.
3. Cursor at (159,3), key 0x41 -> write addr {3,159}=0x039F; cursor (0,4). From (159,44), key 0x41 -> write 0x2C9F; cursor (0,0).
4. clear_req with fill_char=0x20, while key_valid held high:
   - busy=1 and key_ready=0 throughout the clear.
   - Exactly 7200 consecutive we cycles; first addr 0x0000, last 0x2C9F; no addr with col>159.
   - Cursor (0,0) afterwards; keys resume only after the clear.
5. Control characters at cursor (5,2):
   - 0x08 -> write 0x20 at 0x0204; cursor (4,2).
   - 0x0A -> cursor (0,3), we=0.
   - 0x08 at col 0 -> no change, we=0.
6. Edge cases:
   - up_pulse at row 0 -> no change.
   - right_pulse+down_pulse together -> no change.
   - right_pulse coincident with key accept -> only the key effect applies.
   - rst_sync asserted mid-clear -> we=0 immediately; cursor (0,0); IDLE after release.

Source files
------------

// File: rtl/tile_write_ctrl.sv
// Tile BRAM port A owner: arbitrates full-screen clear, character stream writes
// and cursor moves, producing registered one-cycle write strobes at {row, col}.
module tile_write_ctrl #(
  parameter int COLS   = 160,
  parameter int ROWS   = 45,
  parameter int COL_W  = 8,
  parameter int ROW_W  = 6,
  parameter int ADDR_W = 14
) (
  input  logic              clk_75mhz,
  input  logic              rst_sync,
  input  logic              clear_req,
  input  logic [7:0]        fill_char,
  input  logic              key_valid,
  input  logic [7:0]        key_char,
  output logic              key_ready,
  input  logic              up_pulse,
  input  logic              down_pulse,
  input  logic              left_pulse,
  input  logic              right_pulse,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  cur_row,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return ADDR_W'({r, c});
  endfunction

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic [7:0]          fill_q, fill_d;
  logic [COL_W-1:0]    ccol_q, ccol_d;
  logic [ROW_W-1:0]    crow_q, crow_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          din_q, din_d;
  logic [3:0]          moves;

  assign moves = {up_pulse, down_pulse, left_pulse, right_pulse};

  // State and datapath registers
  always_ff @(posedge clk_75mhz or posedge rst_sync) begin
    if (rst_sync) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      fill_q  <= 8'h00;
      ccol_q  <= COL_ZERO;
      crow_q  <= ROW_ZERO;
      col_q   <= COL_ZERO;
      row_q   <= ROW_ZERO;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      din_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      fill_q  <= fill_d;
      ccol_q  <= ccol_d;
      crow_q  <= crow_d;
      col_q   <= col_d;
      row_q   <= row_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  // Next-state, cursor and write-port computation
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    fill_d  = fill_q;
    ccol_d  = ccol_q;
    crow_d  = crow_q;
    col_d   = col_q;
    row_d   = row_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;

    if (clear_req && (state_q != ST_CLEAR)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          // A clear_req arriving on the start edge merges into this clear
          fill_d  = fill_char;
          pend_d  = 1'b0;
          ccol_d  = COL_ZERO;
          crow_d  = ROW_ZERO;
          state_d = ST_CLEAR;
        end else if (key_valid && !clear_req) begin
          state_d = ST_WRITE;
          case (key_char)
            8'h0D: col_d = COL_ZERO;
            8'h0A: begin
              col_d = COL_ZERO;
              row_d = (row_q == ROW_MAX) ? ROW_ZERO : row_q + ROW_ONE;
            end
            8'h08: begin
              if (col_q != COL_ZERO) begin
                col_d  = col_q - COL_ONE;
                we_d   = 1'b1;
                addr_d = pack_addr(row_q, col_q - COL_ONE);
                din_d  = 8'h20;
              end else begin
                col_d  = col_q;
              end
            end
            default: begin
              we_d   = 1'b1;
              addr_d = pack_addr(row_q, col_q);
              din_d  = key_char;
              if (col_q == COL_MAX) begin
                col_d = COL_ZERO;
                row_d = (row_q == ROW_MAX) ? ROW_ZERO : row_q + ROW_ONE;
              end else begin
                col_d = col_q + COL_ONE;
              end
            end
          endcase
        end else begin
          // Only a single one-hot pulse moves; moves saturate at the edges
          case (moves)
            4'b1000: row_d = (row_q != ROW_ZERO) ? row_q - ROW_ONE : row_q;
            4'b0100: row_d = (row_q != ROW_MAX)  ? row_q + ROW_ONE : row_q;
            4'b0010: col_d = (col_q != COL_ZERO) ? col_q - COL_ONE : col_q;
            4'b0001: col_d = (col_q != COL_MAX)  ? col_q + COL_ONE : col_q;
            default: col_d = col_q;
          endcase
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_CLEAR: begin
        we_d   = 1'b1;
        addr_d = pack_addr(crow_q, ccol_q);
        din_d  = fill_q;
        if (ccol_q == COL_MAX) begin
          ccol_d = COL_ZERO;
          if (crow_q == ROW_MAX) begin
            crow_d  = ROW_ZERO;
            col_d   = COL_ZERO;
            row_d   = ROW_ZERO;
            state_d = ST_IDLE;
          end else begin
            crow_d = crow_q + ROW_ONE;
          end
        end else begin
          ccol_d = ccol_q + COL_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Combinational handshake and status outputs
  always_comb begin
    key_ready = (state_q == ST_IDLE) && !pend_q && !clear_req && !rst_sync;
    busy      = (state_q == ST_CLEAR) || pend_q;
  end

  assign bram_we   = we_q;
  assign bram_addr = addr_q;
  assign bram_din  = din_q;
  assign cur_col   = col_q;
  assign cur_row   = row_q;

endmodule

// File: tb/tb_tile_write_ctrl.sv
// Bench for tile_write_ctrl: cycle model over linear screen positions, checked
// every cycle, plus directed scenarios with literal expectations.
module tb_tile_write_ctrl;
  localparam int COLS  = 160;
  localparam int ROWS  = 45;
  localparam int CELLS = COLS * ROWS;

  logic        clk_75mhz = 1'b0;
  logic        rst_sync;
  logic        clear_req, key_valid;
  logic [7:0]  fill_char, key_char;
  logic        up_pulse, down_pulse, left_pulse, right_pulse;
  logic        key_ready, bram_we, busy;
  logic [13:0] bram_addr;
  logic [7:0]  bram_din;
  logic [7:0]  cur_col;
  logic [5:0]  cur_row;

  int n_cmp = 0;
  int n_bad = 0;

  tile_write_ctrl dut (
    .clk_75mhz(clk_75mhz), .rst_sync(rst_sync), .clear_req(clear_req),
    .fill_char(fill_char), .key_valid(key_valid), .key_char(key_char),
    .key_ready(key_ready), .up_pulse(up_pulse), .down_pulse(down_pulse),
    .left_pulse(left_pulse), .right_pulse(right_pulse), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .cur_col(cur_col),
    .cur_row(cur_row), .busy(busy)
  );

  always #5 clk_75mhz = ~clk_75mhz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Model: clear progress as a linear cell index, cursor as (x,y)
  int         m_k = -1;
  bit         m_pend = 0, m_after = 0, m_we = 0;
  int         m_cx = 0, m_cy = 0, m_addr = 0;
  logic [7:0] m_fill = 8'h00, m_din = 8'h00;

  task automatic m_key(input logic [7:0] c);
    int pos;
    pos = m_cy * COLS + m_cx;
    case (c)
      8'h0D: m_cx = 0;
      8'h0A: begin m_cx = 0; m_cy = (m_cy + 1) % ROWS; end
      8'h08: if (m_cx > 0) begin
        m_cx = m_cx - 1; m_we = 1; m_addr = (m_cy << 8) | m_cx; m_din = 8'h20;
      end
      default: begin
        m_we = 1; m_addr = (m_cy << 8) | m_cx; m_din = c;
        pos = (pos + 1) % CELLS;
        m_cx = pos % COLS; m_cy = pos / COLS;
      end
    endcase
  endtask

  task automatic m_step();
    int n;
    m_we = 0;
    if (m_k >= 0) begin
      m_we = 1; m_addr = ((m_k / COLS) << 8) | (m_k % COLS); m_din = m_fill;
      m_k++;
      if (m_k == CELLS) begin m_k = -1; m_cx = 0; m_cy = 0; end
    end else if (m_after) begin
      m_after = 0;
      if (clear_req) m_pend = 1;
    end else if (m_pend) begin
      m_fill = fill_char; m_pend = 0; m_k = 0;
    end else if (key_valid && !clear_req) begin
      m_after = 1;
      m_key(key_char);
    end else begin
      if (clear_req) m_pend = 1;
      n = int'(up_pulse) + int'(down_pulse) + int'(left_pulse) + int'(right_pulse);
      if (n == 1) begin
        if (up_pulse && m_cy > 0) m_cy--;
        if (down_pulse && m_cy < ROWS - 1) m_cy++;
        if (left_pulse && m_cx > 0) m_cx--;
        if (right_pulse && m_cx < COLS - 1) m_cx++;
      end
    end
  endtask

  always @(posedge clk_75mhz or posedge rst_sync) begin
    if (rst_sync) begin
      m_k = -1; m_pend = 0; m_after = 0; m_we = 0;
      m_cx = 0; m_cy = 0; m_addr = 0; m_din = 8'h00; m_fill = 8'h00;
    end else begin
      m_step();
    end
  end

  always @(negedge clk_75mhz) begin
    if (rst_sync === 1'b0) begin
      chk("m_we", bram_we, m_we);
      chk("m_addr", bram_addr, m_addr);
      chk("m_din", bram_din, m_din);
      chk("m_col", cur_col, m_cx);
      chk("m_row", cur_row, m_cy);
      chk("m_ready", key_ready, (m_k < 0) && !m_after && !m_pend && !clear_req);
      chk("m_busy", busy, (m_k >= 0) || m_pend);
    end
  end

  task automatic step();
    @(negedge clk_75mhz);
    #1;
  endtask

  task automatic hold_move(input logic u, d, l, r, input int n);
    up_pulse = u; down_pulse = d; left_pulse = l; right_pulse = r;
    repeat (n) step();
    up_pulse = 1'b0; down_pulse = 1'b0; left_pulse = 1'b0; right_pulse = 1'b0;
  endtask

  task automatic send_key(input logic [7:0] c);
    key_valid = 1'b1; key_char = c;
    step();
  endtask

  task automatic key_done();
    key_valid = 1'b0;
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int nclr, badcol, viol, first_i, last_i, got_key;
    logic [13:0] first_a, last_a, key_a;
    rst_sync = 1'b1;
    clear_req = 1'b0; key_valid = 1'b0; fill_char = 8'h00; key_char = 8'h00;
    up_pulse = 1'b0; down_pulse = 1'b0; left_pulse = 1'b0; right_pulse = 1'b0;
    repeat (3) step();
    chk("rst_we", bram_we, 1'b0);
    chk("rst_addr", bram_addr, 14'h0000);
    chk("rst_ready", key_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_sync = 1'b0;
    #1;
    chk("rel_ready", key_ready, 1'b1);
    chk("rel_cur", {cur_row, cur_col}, 14'h0000);

    // Single printable character at the origin
    send_key(8'h43);
    chk("k43_we", bram_we, 1'b1);
    chk("k43_addr", bram_addr, 14'h0000);
    chk("k43_din", bram_din, 8'h43);
    chk("k43_cur", {cur_row, cur_col}, {6'd0, 8'd1});
    chk("k43_ready", key_ready, 1'b0);
    key_done();
    chk("k43_we_low", bram_we, 1'b0);
    chk("k43_ready_back", key_ready, 1'b1);

    // End-of-line and end-of-screen wrap
    hold_move(1'b0, 1'b1, 1'b0, 1'b0, 3);
    hold_move(1'b0, 1'b0, 1'b0, 1'b1, 159);
    chk("sat_col", cur_col, 8'd159);
    send_key(8'h41);
    chk("eol_addr", bram_addr, 14'h039F);
    chk("eol_cur", {cur_row, cur_col}, {6'd4, 8'd0});
    key_done();
    hold_move(1'b0, 1'b0, 1'b0, 1'b1, 200);
    hold_move(1'b0, 1'b1, 1'b0, 1'b0, 60);
    chk("sat_pos", {cur_row, cur_col}, {6'd44, 8'd159});
    send_key(8'h41);
    chk("eos_addr", bram_addr, 14'h2C9F);
    chk("eos_din", bram_din, 8'h41);
    chk("eos_cur", {cur_row, cur_col}, 14'h0000);
    key_done();

    // Full clear with a key waiting the whole time
    clear_req = 1'b1; fill_char = 8'h20; key_valid = 1'b1; key_char = 8'h58;
    step();
    clear_req = 1'b0;
    chk("clr_busy0", busy, 1'b1);
    chk("clr_ready0", key_ready, 1'b0);
    nclr = 0; badcol = 0; viol = 0; first_i = 0; last_i = 0; got_key = 0;
    first_a = 14'h0; last_a = 14'h0; key_a = 14'h3FFF;
    for (int i = 0; i < 8000 && got_key == 0; i++) begin
      step();
      if (busy && key_ready) viol++;
      if (bram_we && bram_din == 8'h20) begin
        if (nclr == 0) begin first_a = bram_addr; first_i = i; end
        last_a = bram_addr; last_i = i; nclr++;
        if (bram_addr[7:0] >= 8'd160) badcol++;
        if (nclr < CELLS && !busy) viol++;
      end else if (bram_we && bram_din == 8'h58) begin
        got_key = 1; key_a = bram_addr;
        chk("clr_keycur", {cur_row, cur_col}, {6'd0, 8'd1});
      end
    end
    chk("clr_count", nclr, CELLS);
    chk("clr_span", last_i - first_i, CELLS - 1);
    chk("clr_first", first_a, 14'h0000);
    chk("clr_last", last_a, 14'h2C9F);
    chk("clr_badcol", badcol, 0);
    chk("clr_busy_ready", viol, 0);
    chk("clr_key_seen", got_key, 1);
    chk("clr_key_addr", key_a, 14'h0000);
    fill_char = 8'h00;
    key_done();

    // Control characters around (5,2)
    hold_move(1'b0, 1'b1, 1'b0, 1'b0, 2);
    hold_move(1'b0, 1'b0, 1'b0, 1'b1, 4);
    chk("cc_start", {cur_row, cur_col}, {6'd2, 8'd5});
    send_key(8'h08);
    chk("bs_we", bram_we, 1'b1);
    chk("bs_addr", bram_addr, 14'h0204);
    chk("bs_din", bram_din, 8'h20);
    chk("bs_cur", {cur_row, cur_col}, {6'd2, 8'd4});
    key_done();
    send_key(8'h0A);
    chk("lf_we", bram_we, 1'b0);
    chk("lf_cur", {cur_row, cur_col}, {6'd3, 8'd0});
    key_done();
    send_key(8'h08);
    chk("bs0_we", bram_we, 1'b0);
    chk("bs0_cur", {cur_row, cur_col}, {6'd3, 8'd0});
    key_done();

    // Move edge cases
    hold_move(1'b1, 1'b0, 1'b0, 1'b0, 10);
    hold_move(1'b1, 1'b0, 1'b0, 1'b0, 1);
    chk("up_sat", {cur_row, cur_col}, {6'd0, 8'd0});
    hold_move(1'b0, 1'b0, 1'b0, 1'b1, 3);
    hold_move(1'b0, 1'b1, 1'b0, 1'b1, 1);
    chk("multi_move", {cur_row, cur_col}, {6'd0, 8'd3});
    right_pulse = 1'b1;
    send_key(8'h0D);
    right_pulse = 1'b0;
    chk("move_key_cur", {cur_row, cur_col}, {6'd0, 8'd0});
    chk("move_key_we", bram_we, 1'b0);
    key_done();

    // Reset in the middle of a clear
    hold_move(1'b0, 1'b0, 1'b0, 1'b1, 7);
    clear_req = 1'b1; fill_char = 8'h2E;
    step();
    clear_req = 1'b0;
    repeat (12) step();
    chk("mid_we", bram_we, 1'b1);
    chk("mid_cur", {cur_row, cur_col}, {6'd0, 8'd7});
    rst_sync = 1'b1;
    #1;
    chk("ab_we", bram_we, 1'b0);
    chk("ab_cur", {cur_row, cur_col}, 14'h0000);
    chk("ab_busy", busy, 1'b0);
    chk("ab_ready", key_ready, 1'b0);
    repeat (2) step();
    rst_sync = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("ab_no_resume", bram_we, 1'b0);
      step();
    end
    chk("ab_idle_ready", key_ready, 1'b1);
    chk("ab_idle_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
